wbck_arbiter: RTL and testbench

- Writeback stage directly upstream of the general register file: the only source of the file's write port (wbck_dest_wen/idx/dat).
- Arbitrates between the single-cycle ALU result path and the load/store unit (LSU) response path using valid/ready handshakes.
- Registers the winner into a one-cycle writeback output.
- Keeps a pending-load scoreboard so issue logic can detect RAW/WAW hazards against outstanding loads and the in-flight write.

---
 rtl/wbck_arbiter_pkg.sv | 17 +
 rtl/wbck_arbiter_if.sv | 42 ++++
 rtl/wbck_arbiter_scoreboard.sv | 47 ++++
 rtl/wbck_arbiter.sv | 80 ++++++++
 tb/tb_wbck_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wbck_arbiter_pkg.sv
// Shared widths and types for the writeback arbiter and its scoreboard.
package wbck_arbiter_pkg;
    localparam int XLEN        = 32;
    localparam int RFIDX_WIDTH = 5;
    localparam int RFREG_NUM   = 32;
    localparam int STARVE_MAX  = 3;
    localparam int STARVE_W    = $clog2(STARVE_MAX + 1);

    typedef logic [RFIDX_WIDTH-1:0] rfidx_t;
    typedef logic [XLEN-1:0]        xlen_t;
    typedef logic [RFREG_NUM-1:0]   rfvec_t;

    // One-hot register select; index 0 maps to bit 0, which callers mask off.
    function automatic rfvec_t idx_onehot(input rfidx_t idx);
        return rfvec_t'(1) << idx;
    endfunction
endpackage

// File: rtl/wbck_arbiter_if.sv
// Handshake, issue-check and register-file write bundle of the writeback stage.
interface wbck_arbiter_if;
    import wbck_arbiter_pkg::*;

    logic   alu_wbck_valid;
    logic   alu_wbck_ready;
    rfidx_t alu_wbck_idx;
    xlen_t  alu_wbck_dat;
    logic   lsu_wbck_valid;
    logic   lsu_wbck_ready;
    rfidx_t lsu_wbck_idx;
    xlen_t  lsu_wbck_dat;
    logic   lsu_wbck_err;
    logic   lsu_issue_valid;
    rfidx_t lsu_issue_idx;
    rfidx_t chk_src1_idx;
    rfidx_t chk_src2_idx;
    rfidx_t chk_dst_idx;
    logic   chk_hazard;
    logic   wbck_dest_wen;
    rfidx_t wbck_dest_idx;
    xlen_t  wbck_dest_dat;
    logic   wbck_err;

    modport slave (
        input  alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
        input  lsu_wbck_valid, lsu_wbck_idx, lsu_wbck_dat, lsu_wbck_err,
        input  lsu_issue_valid, lsu_issue_idx,
        input  chk_src1_idx, chk_src2_idx, chk_dst_idx,
        output alu_wbck_ready, lsu_wbck_ready, chk_hazard,
        output wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, wbck_err
    );

    modport master (
        output alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
        output lsu_wbck_valid, lsu_wbck_idx, lsu_wbck_dat, lsu_wbck_err,
        output lsu_issue_valid, lsu_issue_idx,
        output chk_src1_idx, chk_src2_idx, chk_dst_idx,
        input  alu_wbck_ready, lsu_wbck_ready, chk_hazard,
        input  wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, wbck_err
    );
endinterface

// File: rtl/wbck_arbiter_scoreboard.sv
// Pending-load scoreboard: tracks outstanding load destinations, flags
// hazards for the issue stage and reports scoreboard protocol violations.
module wbck_scoreboard
    import wbck_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   issue_valid,
    input  rfidx_t issue_idx,
    input  logic   alu_hs,
    input  rfidx_t alu_idx,
    input  logic   lsu_hs,
    input  rfidx_t lsu_idx,
    input  rfidx_t src1_idx,
    input  rfidx_t src2_idx,
    input  rfidx_t dst_idx,
    input  logic   wen,
    input  rfidx_t wen_idx,
    output logic   hazard,
    output logic   err_evt
);
    rfvec_t pending;
    rfvec_t set_vec;
    rfvec_t clr_vec;
    rfvec_t pending_nxt;

    assign set_vec     = (issue_valid && issue_idx != '0) ? idx_onehot(issue_idx) : '0;
    assign clr_vec     = lsu_hs ? idx_onehot(lsu_idx) : '0;
    // Set is applied after clear so a same-cycle reissue keeps the bit.
    assign pending_nxt = (pending & ~clr_vec) | set_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= {pending_nxt[RFREG_NUM-1:1], 1'b0};
    end

    // No write-through in the register file, so the in-flight write also stalls.
    function automatic logic hit(input rfidx_t idx);
        return (idx != '0) && (pending[idx] || (wen && wen_idx == idx));
    endfunction

    assign hazard  = hit(src1_idx) || hit(src2_idx) || hit(dst_idx);

    assign err_evt = (issue_valid && issue_idx != '0 && pending[issue_idx])
                   || (alu_hs && pending[alu_idx])
                   || (lsu_hs && !pending[lsu_idx]);
endmodule

// File: rtl/wbck_arbiter.sv
// Writeback arbiter: LSU-priority grant with ALU starvation boost, registered
// register-file write port and sticky error flag.
module wbck_arbiter
    import wbck_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    wbck_arbiter_if.slave bus
);
    logic [STARVE_W-1:0] starve_cnt;
    logic   boost;
    logic   alu_hs;
    logic   lsu_hs;
    logic   any_hs;
    rfidx_t win_idx;
    xlen_t  win_dat;
    logic   win_wen;
    logic   sb_err;

    assign boost = (starve_cnt == STARVE_W'(STARVE_MAX));

    // Ready is independent of own valid; rst gates both off.
    assign bus.lsu_wbck_ready = !rst && !(boost && bus.alu_wbck_valid);
    assign bus.alu_wbck_ready = !rst && (!bus.lsu_wbck_valid || boost);

    assign alu_hs  = bus.alu_wbck_valid && bus.alu_wbck_ready;
    assign lsu_hs  = bus.lsu_wbck_valid && bus.lsu_wbck_ready;
    assign any_hs  = alu_hs || lsu_hs;
    assign win_idx = lsu_hs ? bus.lsu_wbck_idx : bus.alu_wbck_idx;
    assign win_dat = lsu_hs ? bus.lsu_wbck_dat : bus.alu_wbck_dat;
    assign win_wen = any_hs && (win_idx != '0) && !(lsu_hs && bus.lsu_wbck_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (alu_hs)
            starve_cnt <= '0;
        else if (bus.alu_wbck_valid && !bus.alu_wbck_ready && !boost)
            starve_cnt <= starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wbck_dest_wen <= 1'b0;
            bus.wbck_dest_idx <= '0;
            bus.wbck_dest_dat <= '0;
        end else begin
            bus.wbck_dest_wen <= win_wen;
            if (any_hs) begin
                bus.wbck_dest_idx <= win_idx;
                bus.wbck_dest_dat <= win_dat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.wbck_err <= 1'b0;
        else if (sb_err || (lsu_hs && bus.lsu_wbck_err))
            bus.wbck_err <= 1'b1;
    end

    wbck_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (bus.lsu_issue_valid),
        .issue_idx   (bus.lsu_issue_idx),
        .alu_hs      (alu_hs),
        .alu_idx     (bus.alu_wbck_idx),
        .lsu_hs      (lsu_hs),
        .lsu_idx     (bus.lsu_wbck_idx),
        .src1_idx    (bus.chk_src1_idx),
        .src2_idx    (bus.chk_src2_idx),
        .dst_idx     (bus.chk_dst_idx),
        .wen         (bus.wbck_dest_wen),
        .wen_idx     (bus.wbck_dest_idx),
        .hazard      (bus.chk_hazard),
        .err_evt     (sb_err)
    );
endmodule

// File: tb/tb_wbck_arbiter.sv
// Directed bench for wbck_arbiter: expected writes queued at stimulus time,
// popped and compared by a monitor whenever the DUT asserts wbck_dest_wen.
module tb_wbck_arbiter;
    import wbck_arbiter_pkg::*;

    typedef struct {
        rfidx_t idx;
        xlen_t  dat;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    exp_t exp_q[$];

    wbck_arbiter_if bus ();

    wbck_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.alu_wbck_valid  = 1'b0;
        bus.alu_wbck_idx    = '0;
        bus.alu_wbck_dat    = '0;
        bus.lsu_wbck_valid  = 1'b0;
        bus.lsu_wbck_idx    = '0;
        bus.lsu_wbck_dat    = '0;
        bus.lsu_wbck_err    = 1'b0;
        bus.lsu_issue_valid = 1'b0;
        bus.lsu_issue_idx   = '0;
        bus.chk_src1_idx    = '0;
        bus.chk_src2_idx    = '0;
        bus.chk_dst_idx     = '0;
    endtask

    task automatic push(input rfidx_t idx, input xlen_t dat);
        exp_t e;
        e.idx = idx;
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    // Monitor: every asserted write must match the oldest expected write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.wbck_dest_wen) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got idx %0d dat 0x%0h, expected no write",
                             bus.wbck_dest_idx, bus.wbck_dest_dat);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_idx", 32'(bus.wbck_dest_idx), 32'(e.idx));
                    check("wb_dat", bus.wbck_dest_dat, e.dat);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rfidx_t lsu_seq [5];
        bit     exp_alu [6];
        int     p;
        lsu_seq = '{5'd7, 5'd8, 5'd10, 5'd11, 5'd12};
        exp_alu = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        idle();

        // Reset state; readies stay low even with valids asserted.
        @(negedge clk);
        bus.alu_wbck_valid = 1'b1;
        bus.lsu_wbck_valid = 1'b1;
        #1;
        check("rst_alu_ready", 32'(bus.alu_wbck_ready), 0);
        check("rst_lsu_ready", 32'(bus.lsu_wbck_ready), 0);
        check("rst_wen", 32'(bus.wbck_dest_wen), 0);
        check("rst_idx", 32'(bus.wbck_dest_idx), 0);
        check("rst_dat", bus.wbck_dest_dat, 0);
        check("rst_err", 32'(bus.wbck_err), 0);
        @(negedge clk);
        idle();
        rst = 1'b0;

        // Lone ALU result.
        @(negedge clk);
        bus.alu_wbck_valid = 1'b1;
        bus.alu_wbck_idx   = 5'd5;
        bus.alu_wbck_dat   = 32'h1234;
        #1;
        check("alu_ready_alone", 32'(bus.alu_wbck_ready), 1);
        check("lsu_ready_idle", 32'(bus.lsu_wbck_ready), 1);
        push(5'd5, 32'h1234);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("wen_drop", 32'(bus.wbck_dest_wen), 0);

        // Issue loads, then contend ALU vs LSU every cycle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle();
            bus.lsu_issue_valid = 1'b1;
            bus.lsu_issue_idx   = lsu_seq[i];
        end
        @(negedge clk);
        idle();
        bus.chk_src2_idx = 5'd10;
        bus.chk_dst_idx  = 5'd13;
        #1;
        check("hazard_src2_pending", 32'(bus.chk_hazard), 1);
        bus.chk_src2_idx = 5'd0;
        #1;
        check("hazard_dst_clear", 32'(bus.chk_hazard), 0);
        p = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            idle();
            bus.alu_wbck_valid = 1'b1;
            bus.alu_wbck_idx   = 5'd3;
            bus.alu_wbck_dat   = 32'h333;
            bus.lsu_wbck_valid = 1'b1;
            bus.lsu_wbck_idx   = lsu_seq[p];
            bus.lsu_wbck_dat   = 32'h700 + 32'(p);
            #1;
            check("contend_alu_ready", 32'(bus.alu_wbck_ready), 32'(exp_alu[c]));
            check("contend_lsu_ready", 32'(bus.lsu_wbck_ready), 32'(!exp_alu[c]));
            if (exp_alu[c]) push(5'd3, 32'h333);
            else begin
                push(lsu_seq[p], 32'h700 + 32'(p));
                p++;
            end
        end
        @(negedge clk);
        idle();

        // Load to r9: hazard through pending, then through the in-flight write.
        @(negedge clk);
        idle();
        bus.lsu_issue_valid = 1'b1;
        bus.lsu_issue_idx   = 5'd9;
        @(negedge clk);
        idle();
        bus.chk_src1_idx   = 5'd9;
        bus.lsu_wbck_valid = 1'b1;
        bus.lsu_wbck_idx   = 5'd9;
        bus.lsu_wbck_dat   = 32'hCAFE;
        #1;
        check("hazard_r9_pending", 32'(bus.chk_hazard), 1);
        check("lsu_ready_r9", 32'(bus.lsu_wbck_ready), 1);
        push(5'd9, 32'hCAFE);
        @(negedge clk);
        idle();
        bus.chk_src1_idx = 5'd9;
        #1;
        check("hazard_r9_inflight", 32'(bus.chk_hazard), 1);
        @(negedge clk);
        #1;
        check("hazard_r9_done", 32'(bus.chk_hazard), 0);

        // Write to r0: accepted, never written, never a hazard.
        @(negedge clk);
        idle();
        bus.alu_wbck_valid = 1'b1;
        bus.alu_wbck_idx   = 5'd0;
        bus.alu_wbck_dat   = 32'hFFFF_FFFF;
        #1;
        check("alu_ready_r0", 32'(bus.alu_wbck_ready), 1);
        @(negedge clk);
        idle();
        #1;
        check("r0_wen", 32'(bus.wbck_dest_wen), 0);
        check("r0_idx", 32'(bus.wbck_dest_idx), 0);
        check("r0_dat", bus.wbck_dest_dat, 32'hFFFF_FFFF);
        check("r0_hazard", 32'(bus.chk_hazard), 0);
        @(negedge clk);
        check("hold_dat", bus.wbck_dest_dat, 32'hFFFF_FFFF);
        check("err_clean", 32'(bus.wbck_err), 0);

        // Errored load to r4.
        idle();
        bus.lsu_issue_valid = 1'b1;
        bus.lsu_issue_idx   = 5'd4;
        @(negedge clk);
        idle();
        bus.lsu_wbck_valid = 1'b1;
        bus.lsu_wbck_idx   = 5'd4;
        bus.lsu_wbck_dat   = 32'h44;
        bus.lsu_wbck_err   = 1'b1;
        #1;
        check("lsu_ready_err", 32'(bus.lsu_wbck_ready), 1);
        @(negedge clk);
        idle();
        bus.chk_src1_idx = 5'd4;
        #1;
        check("err_wen", 32'(bus.wbck_dest_wen), 0);
        check("err_idx", 32'(bus.wbck_dest_idx), 4);
        check("err_flag", 32'(bus.wbck_err), 1);
        check("err_pending_clr", 32'(bus.chk_hazard), 0);
        @(negedge clk);
        check("err_sticky", 32'(bus.wbck_err), 1);

        // Same-cycle reissue and response on r6: set wins.
        idle();
        bus.lsu_issue_valid = 1'b1;
        bus.lsu_issue_idx   = 5'd6;
        @(negedge clk);
        bus.lsu_wbck_valid = 1'b1;
        bus.lsu_wbck_idx   = 5'd6;
        bus.lsu_wbck_dat   = 32'h66;
        #1;
        check("lsu_ready_r6", 32'(bus.lsu_wbck_ready), 1);
        push(5'd6, 32'h66);
        @(negedge clk);
        idle();
        @(negedge clk);
        bus.chk_src1_idx = 5'd6;
        #1;
        check("r6_still_pending", 32'(bus.chk_hazard), 1);

        // Reset with a write in flight.
        bus.alu_wbck_valid = 1'b1;
        bus.alu_wbck_idx   = 5'd2;
        bus.alu_wbck_dat   = 32'h22;
        @(posedge clk);
        #1;
        check("pre_rst_wen", 32'(bus.wbck_dest_wen), 1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_wen", 32'(bus.wbck_dest_wen), 0);
        check("mid_rst_idx", 32'(bus.wbck_dest_idx), 0);
        check("mid_rst_dat", bus.wbck_dest_dat, 0);
        check("mid_rst_err", 32'(bus.wbck_err), 0);
        check("mid_rst_hazard", 32'(bus.chk_hazard), 0);
        check("mid_rst_alu_ready", 32'(bus.alu_wbck_ready), 0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
